// File: rtl/request_arbiter_bridge.sv
// Arbitrates N_MASTER request channels onto one slave port and routes the one-cycle response back.
// Define REQ_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.

module request_arbiter_bridge_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             active,
  input  logic             found,
  input  logic [IDX_W-1:0] win,
  input  logic             slv_gnt,
  input  logic             pend,
  input  logic [IDX_W-1:0] idx,
  input  logic             rsp_valid,
  output logic             gnt,
  output logic             valid
);
  localparam logic [IDX_W-1:0] ID = IDX_W'(LANE);

  assign gnt   = active && found && (win == ID) && slv_gnt;
  assign valid = active && pend && (idx == ID) && rsp_valid;
endmodule

module request_arbiter_bridge #(
  parameter int N_MASTER   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int AUX_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTER-1:0]                  data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
  input  logic [N_MASTER-1:0]                  data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
  input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]   data_aux_i,
  output logic [N_MASTER-1:0]                  data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [AUX_WIDTH-1:0]                 data_aux_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
  input  logic                                 data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]                 data_r_aux_i,
  output logic [N_MASTER-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_opc_o,
  output logic [AUX_WIDTH-1:0]                 data_r_aux_o
);
  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_MASTER - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [AUX_WIDTH-1:0]  aux;
  } req_t;

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             hs;
  logic             pend_q;
  logic [IDX_W-1:0] idx_q;
  req_t             req_sel;

`ifdef REQ_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] rr_q;

  assign start = rr_q;

  always_ff @(posedge clk) begin
    if (!rst_n)  rr_q <= '0;
    else if (hs) rr_q <= (win == LAST) ? '0 : win + 1'b1;
  end
`endif

  // Scan upward from the start index with wrap; first requester wins.
  always_comb begin
    int j;
    j     = 0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      j = (int'(start) + i) % N_MASTER;
      if (!found && data_req_i[j]) begin
        found = 1'b1;
        win   = j[IDX_W-1:0];
      end
    end
  end

  assign data_req_o = rst_n && found;
  assign hs         = data_req_o && data_gnt_i;

  always_comb begin
    req_sel = '0;
    if (data_req_o) begin
      req_sel.add   = data_add_i[win];
      req_sel.wen   = data_wen_i[win];
      req_sel.wdata = data_wdata_i[win];
      req_sel.be    = data_be_i[win];
      req_sel.aux   = data_aux_i[win];
    end
  end

  assign data_add_o   = req_sel.add;
  assign data_wen_o   = req_sel.wen;
  assign data_wdata_o = req_sel.wdata;
  assign data_be_o    = req_sel.be;
  assign data_aux_o   = req_sel.aux;

  // Response routing state: remembers who won the last handshake for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      pend_q <= hs;
      if (hs) idx_q <= win;
    end
  end

  for (genvar m = 0; m < N_MASTER; m++) begin : g_lane
    request_arbiter_bridge_lane #(
      .IDX_W (IDX_W),
      .LANE  (m)
    ) u_lane (
      .active    (rst_n),
      .found     (found),
      .win       (win),
      .slv_gnt   (data_gnt_i),
      .pend      (pend_q),
      .idx       (idx_q),
      .rsp_valid (data_r_valid_i),
      .gnt       (data_gnt_o[m]),
      .valid     (data_r_valid_o[m])
    );
  end

  assign data_r_rdata_o = data_r_rdata_i;
  assign data_r_opc_o   = data_r_opc_i;
  assign data_r_aux_o   = data_r_aux_i;
endmodule
